// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between execute and write-back.
// Holds one instruction at a time. Loads and stores go out on the data port with a
// valid/ready handshake. Load data is aligned and extended before write-back; other
// instructions pass through with one cycle of latency.
// Optional build macro: MEM_MISALIGN_TRAP_EN. When it is defined, a misaligned half or
// word access raises out_err and never reaches the data port.
module mem_access_stage #(
  parameter int unsigned SIDE_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_store_data,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_load_data,
  output logic [31:0]       out_alu_result,
  output logic [SIDE_W-1:0] out_side,
  output logic              out_err,
  output logic              dreq_valid,
  input  logic              dreq_ready,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic              dreq_wen,
  output logic [31:0]       dreq_wdata,
  output logic [3:0]        dreq_wstrb,
  input  logic              dresp_valid,
  input  logic [31:0]       dresp_rdata,
  input  logic              dresp_err
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StHold} state_e;

  state_e            state_q, state_d;
  logic              is_load_q, is_load_d;
  logic              is_store_q, is_store_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       store_data_q, store_data_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              err_q, err_d;

  logic [1:0]  offset;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_aligned;
  logic [31:0] addr_word;

`ifdef MEM_MISALIGN_TRAP_EN
  logic in_misaligned;
  // Half needs addr[0]=0; word (and the unused size encoding) needs addr[1:0]=0.
  assign in_misaligned = (in_size == 2'b01) ? in_alu_result[0]
                       : (in_size[1] && (in_alu_result[1:0] != 2'b00));
`endif

  assign offset    = alu_q[1:0];
  assign addr_word = {alu_q[31:2], 2'b00};

  // Select and extend the addressed byte/half lane of the incoming read word.
  always_comb begin
    rd_byte = dresp_rdata[{offset, 3'b000} +: 8];
    rd_half = offset[1] ? dresp_rdata[31:16] : dresp_rdata[15:0];
    unique case (size_q)
      2'b00:   load_aligned = unsigned_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_aligned = unsigned_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_aligned = dresp_rdata;
    endcase
  end

  // Request fields come from captured state only, so they hold steady while stalled.
  always_comb begin
    dreq_valid = (state_q == StReq);
    dreq_addr  = ADDR_W'(addr_word);
    dreq_wen   = is_store_q;
    unique case (size_q)
      2'b00: begin
        dreq_wdata = {4{store_data_q[7:0]}};
        dreq_wstrb = 4'b0001 << offset;
      end
      2'b01: begin
        dreq_wdata = {2{store_data_q[15:0]}};
        dreq_wstrb = 4'b0011 << {offset[1], 1'b0};
      end
      default: begin
        dreq_wdata = store_data_q;
        dreq_wstrb = 4'b1111;
      end
    endcase
    // Reads carry no byte enables.
    if (!is_store_q) begin
      dreq_wstrb = 4'b0000;
    end
  end

  // Output bundle and upstream readiness follow the FSM state.
  always_comb begin
    in_ready       = (state_q == StIdle);
    out_valid      = (state_q == StHold);
    out_load_data  = load_data_q;
    out_alu_result = alu_q;
    out_side       = side_q;
    out_err        = err_q;
  end

  // Next-state: capture on accept, walk request/response, release on out_ready.
  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    alu_d        = alu_q;
    store_data_d = store_data_q;
    side_d       = side_q;
    load_data_d  = load_data_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Both rd and wr set is treated as a store.
          is_load_d    = in_mem_rd & ~in_mem_wr;
          is_store_d   = in_mem_wr;
          size_d       = in_size;
          unsigned_d   = in_unsigned;
          alu_d        = in_alu_result;
          store_data_d = in_store_data;
          side_d       = in_side;
          load_data_d  = 32'b0;
          err_d        = 1'b0;
          state_d      = (in_mem_rd | in_mem_wr) ? StReq : StHold;
`ifdef MEM_MISALIGN_TRAP_EN
          if ((in_mem_rd | in_mem_wr) && in_misaligned) begin
            err_d   = 1'b1;
            state_d = StHold;
          end
`endif
        end
      end
      StReq: begin
        // A response in the handshake cycle is not legal and is ignored.
        if (dreq_ready) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (dresp_valid) begin
          err_d       = dresp_err;
          load_data_d = (is_load_q && !dresp_err) ? load_aligned : 32'b0;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      alu_q        <= 32'b0;
      store_data_q <= 32'b0;
      side_q       <= '0;
      load_data_q  <= 32'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      alu_q        <= alu_d;
      store_data_q <= store_data_d;
      side_q       <= side_d;
      load_data_q  <= load_data_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized transactions
// against a behavioural model of load alignment, store lanes and handshake timing.
module tb_mem_access_stage;
  localparam int unsigned SIDE_W = 64;
  localparam int unsigned ADDR_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_mem_rd, in_mem_wr, in_unsigned;
  logic [1:0]        in_size;
  logic [31:0]       in_alu_result, in_store_data;
  logic [SIDE_W-1:0] in_side;
  logic              out_valid, out_ready, out_err;
  logic [31:0]       out_load_data, out_alu_result;
  logic [SIDE_W-1:0] out_side;
  logic              dreq_valid, dreq_ready, dreq_wen;
  logic [ADDR_W-1:0] dreq_addr;
  logic [31:0]       dreq_wdata;
  logic [3:0]        dreq_wstrb;
  logic              dresp_valid, dresp_err;
  logic [31:0]       dresp_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.SIDE_W(SIDE_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data), .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready), .out_load_data(out_load_data),
    .out_alu_result(out_alu_result), .out_side(out_side), .out_err(out_err),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
    .dreq_wen(dreq_wen), .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb),
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata), .dresp_err(dresp_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: pick the addressed lane arithmetically and extend by subtraction.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] v;
    int unsigned o;
    o = addr % 4;
    if (size == 2'd0) begin
      v = (rdata >> (8 * o)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (size == 2'd1) begin
      v = (rdata >> ((o >= 2) ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] size);
    if (size == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [31:0] addr, input logic [1:0] size);
    int unsigned o;
    o = addr % 4;
    if (size == 2'd0) return 4'(1 << o);
    if (size == 2'd1) return (o >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic model_misaligned(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd1) return (addr % 2) != 0;
    if (size == 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction
`endif

  task automatic scramble_inputs();
    in_mem_rd     = 1'($urandom);
    in_mem_wr     = 1'($urandom);
    in_size       = 2'($urandom);
    in_unsigned   = 1'($urandom);
    in_alu_result = $urandom;
    in_store_data = $urandom;
    in_side       = {$urandom, $urandom};
  endtask

  // One full transaction: accept, optional memory access with stalls, hold, release.
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] alu, input logic [31:0] sdata,
                         input logic [63:0] side, input logic [31:0] rdata, input logic rerr,
                         input int dstall, input int rlat, input int ostall);
    logic        mem, trap;
    logic [31:0] exp_load;
    logic        exp_err;
    mem  = rd | wr;
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = mem && model_misaligned(alu, size);
`endif
    check_eq("idle_in_ready", in_ready, 1);
    in_mem_rd = rd; in_mem_wr = wr; in_size = size; in_unsigned = uns;
    in_alu_result = alu; in_store_data = sdata; in_side = side; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    scramble_inputs();
    check_eq("busy_in_ready", in_ready, 0);
    if (mem && !trap) begin
      for (int i = 0; i <= dstall; i++) begin
        check_eq("dreq_valid", dreq_valid, 1);
        check_eq("dreq_addr", dreq_addr, alu & 32'hFFFF_FFFC);
        check_eq("dreq_wen", dreq_wen, wr);
        if (wr) begin
          check_eq("dreq_wdata", dreq_wdata, model_wdata(sdata, size));
          check_eq("dreq_wstrb", dreq_wstrb, model_wstrb(alu, size));
        end
        check_eq("req_in_ready", in_ready, 0);
        check_eq("req_out_valid", out_valid, 0);
        if (i == dstall) begin
          // Illegal same-cycle response; the stage must ignore it.
          dreq_ready = 1'b1; dresp_valid = 1'b1; dresp_rdata = ~rdata; dresp_err = 1'b1;
        end
        @(negedge clock);
      end
      dreq_ready = 1'b0; dresp_valid = 1'b0;
      check_eq("dreq_dropped", dreq_valid, 0);
      for (int i = 0; i < rlat; i++) begin
        check_eq("resp_wait_out_valid", out_valid, 0);
        @(negedge clock);
      end
      dresp_valid = 1'b1; dresp_rdata = rdata; dresp_err = rerr;
      @(negedge clock);
      dresp_valid = 1'b0; dresp_rdata = $urandom; dresp_err = 1'b0;
      exp_err  = rerr;
      exp_load = (rd && !wr && !rerr) ? model_load(rdata, alu, size, uns) : 32'h0;
    end else begin
      exp_err  = trap;
      exp_load = 32'h0;
    end
    for (int i = 0; i <= ostall; i++) begin
      check_eq("hold_out_valid", out_valid, 1);
      check_eq("hold_load_data", out_load_data, exp_load);
      check_eq("hold_err", out_err, exp_err);
      check_eq("hold_alu", out_alu_result, alu);
      check_eq("hold_side", out_side, side);
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_dreq_valid", dreq_valid, 0);
      // Upstream offers a new item while stalled; it must not be taken.
      in_valid  = (i < ostall);
      out_ready = (i == ostall);
      @(negedge clock);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("release_out_valid", out_valid, 0);
    check_eq("release_in_ready", in_ready, 1);
    check_eq("release_dreq_valid", dreq_valid, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_rdata = '0; dresp_err = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_dreq_valid", dreq_valid, 0);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_load_data", out_load_data, 0);
    check_eq("rst_alu", out_alu_result, 0);
    check_eq("rst_side", out_side, 0);

    // ALU pass-through.
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 64'hCAFE, 32'h0, 1'b0, 0, 0, 0);
    // Signed and unsigned byte load from lane 3.
    run_txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 64'h1, 32'h80FF_0000, 1'b0, 0, 1, 0);
    run_txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 64'h2, 32'h80FF_0000, 1'b0, 1, 0, 0);
    // Half store with request stall and output stall.
    run_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'hABCD, 64'h3, 32'h0, 1'b0, 5, 2, 3);
    // Load with bus error.
    run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 64'h4, 32'h1234_5678, 1'b1, 0, 0, 1);
    // Misaligned word load (traps when the feature is built in).
    run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 64'h5, 32'hDEAD_BEEF, 1'b0, 0, 0, 0);
    // rd and wr both set behaves as a store.
    run_txn(1'b1, 1'b1, 2'd0, 1'b0, 32'h41, 32'h77, 64'h6, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);

    // Reset while waiting for a response, then a late response arrives.
    in_mem_rd = 1'b1; in_mem_wr = 1'b0; in_size = 2'd2; in_alu_result = 32'h300;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; dreq_ready = 1'b1;
    @(negedge clock);
    dreq_ready = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; dresp_valid = 1'b1; dresp_rdata = 32'h5555_AAAA; dresp_err = 1'b1;
    @(negedge clock);
    dresp_valid = 1'b0; dresp_err = 1'b0;
    check_eq("late_resp_out_valid", out_valid, 0);
    check_eq("late_resp_in_ready", in_ready, 1);
    check_eq("late_resp_err", out_err, 0);
    check_eq("late_resp_dreq", dreq_valid, 0);
    @(negedge clock);
    check_eq("late_resp_out_valid2", out_valid, 0);

    for (int n = 0; n < 150; n++) begin
      run_txn(1'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), $urandom,
              $urandom, {$urandom, $urandom}, $urandom, ($urandom_range(0, 7) == 0),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
